e_q_bus_scheduler: RTL and testbench

Generates the 6809 quadrature bus clocks E and Q from the system clock, and sequences each bus cycle into four phases. Supports memory-ready (MRDY) stretching of the E-high half for slow peripherals. Time-shares the E-low window of each cycle with one secondary bus master (DMA/video) through a req/gnt handshake. Sits between the system clock and the CPU core, memory decode and DMA engine; it replaces the free-running quadrature generator.

---
 rtl/e_q_bus_scheduler.sv | 173 +++++++++++++++++
 tb/tb_e_q_bus_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_q_bus_scheduler.sv
// e_q_bus_scheduler: 6809 quadrature E/Q clock generator and bus-cycle sequencer.
// Each bus cycle is four phases (P0..P3) of PHASE_DIV clocks each. mrdy=0 on the
// last clock of P3 stretches the E-high half. A secondary master can own P0..P1
// through dma_req/dma_gnt. run=0 parks the sequencer at the P3->P0 boundary.
// Optional feature macro: STRETCH_TIMEOUT_EN bounds a stretch to MAX_STRETCH
// clocks and latches stretch_timeout; without it stretch_timeout is tied 0.
//
// Handshake: dma_req is sampled only on the edge that enters P0. When it is 1
// there, dma_gnt is 1 from the first clock of P0 through the last clock of P1.
// The requester holds dma_req until it observes dma_gnt; changes at any other
// time are ignored until the next P0 entry.
module e_q_bus_scheduler #(
    parameter int PHASE_DIV   = 1,
    parameter int DIV_W       = 4,
    parameter int MAX_STRETCH = 15,
    parameter int STR_W       = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic mrdy,
    input  logic dma_req,
    output logic E,
    output logic Q,
    output logic cycle_start,
    output logic cycle_end,
    output logic dma_gnt,
    output logic stretching,
    output logic stretch_timeout
);

    typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);

    phase_t           phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             e_q, e_d;
    logic             qclk_q, qclk_d;
    logic             gnt_q, gnt_d;
    logic             start_q, start_d;
    // held_q: parked in P3 after a boundary with run=0, or straight out of reset
    logic             held_q, held_d;
    logic             enter_p0;
    logic             end_c;
    logic             stretch_c;
    logic             limit_hit;
    logic             done;

`ifdef STRETCH_TIMEOUT_EN
    localparam logic [STR_W-1:0] STR_MAX = STR_W'(MAX_STRETCH);
    logic [STR_W-1:0] str_cnt_q, str_cnt_d;
    logic             timeout_q, timeout_d;
    assign limit_hit = (str_cnt_q == STR_MAX);
`else
    logic unused_stretch_cfg;
    assign unused_stretch_cfg = ^{STR_W'(MAX_STRETCH)};
    assign limit_hit = 1'b0;
`endif

    assign done = mrdy | limit_hit;

    // Next-state: divider/phase advance, stretch hold, run parking and grant sampling
    always_comb begin
        phase_d   = phase_q;
        div_d     = div_q;
        held_d    = held_q;
        gnt_d     = gnt_q;
        start_d   = 1'b0;
        enter_p0  = 1'b0;
        end_c     = 1'b0;
        stretch_c = 1'b0;
`ifdef STRETCH_TIMEOUT_EN
        str_cnt_d = str_cnt_q;
        timeout_d = timeout_q;
`endif
        if (held_q) begin
            if (run) enter_p0 = 1'b1;
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            case (phase_q)
                P0: begin
                    phase_d = P1;
                    div_d   = '0;
                end
                P1: begin
                    phase_d = P2;
                    div_d   = '0;
                    gnt_d   = 1'b0;
                end
                P2: begin
                    phase_d = P3;
                    div_d   = '0;
                end
                P3: begin
                    if (!done) begin
                        stretch_c = 1'b1;
`ifdef STRETCH_TIMEOUT_EN
                        str_cnt_d = str_cnt_q + STR_W'(1);
`endif
                    end else begin
                        end_c = 1'b1;
`ifdef STRETCH_TIMEOUT_EN
                        if (limit_hit) timeout_d = 1'b1;
`endif
                        if (run) enter_p0 = 1'b1;
                        else     held_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (enter_p0) begin
            phase_d = P0;
            div_d   = '0;
            held_d  = 1'b0;
            gnt_d   = dma_req;
            start_d = 1'b1;
`ifdef STRETCH_TIMEOUT_EN
            str_cnt_d = '0;
`endif
        end
        e_d    = (phase_d == P2) || (phase_d == P3);
        qclk_d = (phase_d == P1) || (phase_d == P2);
    end

    // State and registered bus clocks; reset parks in P3 with E high
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q <= P3;
            div_q   <= DIV_LAST;
            e_q     <= 1'b1;
            qclk_q  <= 1'b0;
            gnt_q   <= 1'b0;
            start_q <= 1'b0;
            held_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            e_q     <= e_d;
            qclk_q  <= qclk_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            held_q  <= held_d;
        end
    end

`ifdef STRETCH_TIMEOUT_EN
    // Stretch length counter and sticky timeout flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            str_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            str_cnt_q <= str_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign stretch_timeout = timeout_q;
`else
    assign stretch_timeout = 1'b0;
`endif

    assign E           = e_q;
    assign Q           = qclk_q;
    assign dma_gnt     = gnt_q;
    assign cycle_start = start_q;
    // cycle_end and stretching depend on this clock's mrdy/run; reset overrides them
    assign cycle_end   = end_c & reset_n;
    assign stretching  = stretch_c & reset_n;

endmodule

// File: tb/tb_e_q_bus_scheduler.sv
// tb_e_q_bus_scheduler: directed bench for e_q_bus_scheduler.
// Instance u_d1 runs PHASE_DIV=1, u_d3 runs PHASE_DIV=3; both share the inputs.
module tb_e_q_bus_scheduler;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b1;
  logic mrdy = 1'b1;
  logic dma_req = 1'b0;

  logic e1, q1, cs1, ce1, g1, st1, to1;
  logic e3, q3, cs3, ce3, g3, st3, to3;

  int n_tests = 0;
  int n_fail = 0;

  e_q_bus_scheduler #(.PHASE_DIV(1), .DIV_W(4), .MAX_STRETCH(15), .STR_W(4)) u_d1 (
    .clock(clock), .reset_n(reset_n), .run(run), .mrdy(mrdy), .dma_req(dma_req),
    .E(e1), .Q(q1), .cycle_start(cs1), .cycle_end(ce1), .dma_gnt(g1),
    .stretching(st1), .stretch_timeout(to1)
  );

  e_q_bus_scheduler #(.PHASE_DIV(3), .DIV_W(4), .MAX_STRETCH(15), .STR_W(4)) u_d3 (
    .clock(clock), .reset_n(reset_n), .run(run), .mrdy(mrdy), .dma_req(dma_req),
    .E(e3), .Q(q3), .cycle_start(cs3), .cycle_end(ce3), .dma_gnt(g3),
    .stretching(st3), .stretch_timeout(to3)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in its post-reset parked state; the next tick is clock 1 (P0)
  task automatic reset_dut(input logic run_v, input logic req_v);
    reset_n = 1'b0;
    run = run_v;
    mrdy = 1'b1;
    dma_req = req_v;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    mrdy = 1'b0;
    run = 1'b1;
    dma_req = 1'b1;
    tick();
    tick();
    #1;
    n_tests++;
    if ({e1, q1, cs1, ce1, g1, st1, to1} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_state d1 got %b want %b", {e1, q1, cs1, ce1, g1, st1, to1}, 7'b1000000);
    end
    n_tests++;
    if ({e3, q3, g3, st3} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state d3 got %b want %b", {e3, q3, g3, st3}, 4'b1000);
    end
    reset_n = 1'b1;
    mrdy = 1'b1;
    dma_req = 1'b0;
    #1;
    n_tests++;
    if ({ce1, st1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle got %b want %b", {ce1, st1}, 2'b00);
    end
    tick();
    #1;
    n_tests++;
    if ({e1, q1, cs1, ce1} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_first_p0 got %b want %b", {e1, q1, cs1, ce1}, 4'b0010);
    end
  endtask

  task automatic test_div1;
    logic [3:0] exp;
    int ph;
    reset_dut(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      #1;
      ph = (k - 1) % 4;
      exp = {(ph == 2 || ph == 3), (ph == 1 || ph == 2), (ph == 0), (ph == 3)};
      n_tests++;
      if ({e1, q1, cs1, ce1} !== exp) begin
        n_fail++;
        $display("FAIL div1_seq clk %0d got %b want %b", k, {e1, q1, cs1, ce1}, exp);
      end
    end
  endtask

  task automatic test_div3;
    logic [3:0] exp;
    int ph;
    reset_dut(1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      #1;
      ph = ((k - 1) / 3) % 4;
      exp = {(ph == 2 || ph == 3), (ph == 1 || ph == 2), ((k - 1) % 12 == 0), (k % 12 == 0)};
      n_tests++;
      if ({e3, q3, cs3, ce3} !== exp) begin
        n_fail++;
        $display("FAIL div3_seq clk %0d got %b want %b", k, {e3, q3, cs3, ce3}, exp);
      end
    end
  endtask

  task automatic test_stretch;
    int e_cnt = 0;
    int st_cnt = 0;
    int ce_cnt = 0;
    int cs_cnt = 0;
    reset_dut(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      mrdy = !(k >= 4 && k <= 8);
      #1;
      e_cnt += int'(e1);
      st_cnt += int'(st1);
      ce_cnt += int'(ce1);
      cs_cnt += int'(cs1);
      if (k == 6) begin
        n_tests++;
        if ({e1, q1, st1, ce1, to1} !== 5'b10100) begin
          n_fail++;
          $display("FAIL stretch_mid got %b want %b", {e1, q1, st1, ce1, to1}, 5'b10100);
        end
      end
      if (k == 9) begin
        n_tests++;
        if ({st1, ce1} !== 2'b01) begin
          n_fail++;
          $display("FAIL stretch_release got %b want %b", {st1, ce1}, 2'b01);
        end
      end
    end
    mrdy = 1'b1;
    n_tests++;
    if (e_cnt != 7) begin
      n_fail++;
      $display("FAIL stretch_e_high got %0d want %0d", e_cnt, 7);
    end
    n_tests++;
    if (st_cnt != 5) begin
      n_fail++;
      $display("FAIL stretch_count got %0d want %0d", st_cnt, 5);
    end
    n_tests++;
    if (ce_cnt != 1 || cs_cnt != 2) begin
      n_fail++;
      $display("FAIL stretch_pulses got ce=%0d cs=%0d want ce=1 cs=2", ce_cnt, cs_cnt);
    end
  endtask

  task automatic test_dma;
    logic exp;
    reset_dut(1'b1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      dma_req = (k <= 7) || (k >= 10);
      #1;
      exp = (((k - 1) % 4) < 2) && (k < 9 || k >= 13);
      n_tests++;
      if (g1 !== exp) begin
        n_fail++;
        $display("FAIL dma_gnt clk %0d got %b want %b", k, g1, exp);
      end
    end
    dma_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    reset_dut(1'b1, 1'b1);
    tick();
    #1;
    n_tests++;
    if ({e1, q1, g1, cs1} !== 4'b0011) begin
      n_fail++;
      $display("FAIL midreset_pre got %b want %b", {e1, q1, g1, cs1}, 4'b0011);
    end
    reset_n = 1'b0;
    mrdy = 1'b0;
    tick();
    #1;
    n_tests++;
    if ({e1, q1, g1, cs1, st1, ce1} !== 6'b100000) begin
      n_fail++;
      $display("FAIL midreset_abort got %b want %b", {e1, q1, g1, cs1, st1, ce1}, 6'b100000);
    end
    reset_n = 1'b1;
    mrdy = 1'b1;
    dma_req = 1'b0;
  endtask

  task automatic test_run;
    logic [3:0] tbl [8];
    tbl = '{4'b0010, 4'b0100, 4'b1100, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0010};
    reset_dut(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      run = !(k >= 3 && k <= 6);
      #1;
      n_tests++;
      if ({e1, q1, cs1, ce1} !== tbl[k-1]) begin
        n_fail++;
        $display("FAIL run_hold clk %0d got %b want %b", k, {e1, q1, cs1, ce1}, tbl[k-1]);
      end
    end
    run = 1'b1;
  endtask

`ifdef STRETCH_TIMEOUT_EN
  task automatic test_timeout;
    reset_dut(1'b1, 1'b0);
    mrdy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      #1;
      if (k == 18) begin
        n_tests++;
        if ({st1, ce1, to1} !== 3'b100) begin
          n_fail++;
          $display("FAIL timeout_last_stretch got %b want %b", {st1, ce1, to1}, 3'b100);
        end
      end
      if (k == 19) begin
        n_tests++;
        if ({st1, ce1} !== 2'b01) begin
          n_fail++;
          $display("FAIL timeout_end got %b want %b", {st1, ce1}, 2'b01);
        end
      end
      if (k == 20) begin
        n_tests++;
        if ({to1, cs1} !== 2'b11) begin
          n_fail++;
          $display("FAIL timeout_sticky got %b want %b", {to1, cs1}, 2'b11);
        end
      end
    end
    reset_dut(1'b1, 1'b0);
    n_tests++;
    if (to1 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear got %b want %b", to1, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_stretch();
    test_dma();
    test_reset_mid();
    test_run();
`ifdef STRETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
